// File: rtl/wb_write_queue_pkg.sv
// Shared constants and entry type for the writeback write queue.
package wb_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [REG_W-1:0]  regId;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Producer push handshake plus register-file write port of the writeback queue.
interface wb_write_queue_if import wb_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_reg;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic              WriteReg;

  modport slave (
    input  in_valid, in_reg, in_data, drain_en,
    output in_ready, DstReg, DstData, WriteReg
  );

  modport master (
    output in_valid, in_reg, in_data, drain_en,
    input  in_ready, DstReg, DstData, WriteReg
  );

endinterface

// File: rtl/wb_write_queue_fwd_match.sv
// Youngest-first register-ID search over the valid queue entries (head .. head+count-1).
// WB_R0_DISCARD_EN: lookups of register 0 never hit.
module wb_fwd_match import wb_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH):0]       count,
  input  logic [REG_W-1:0]             srcReg,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] idx;

  // Scan oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PtrW'(i);
      if ((CntW'(i) < count) && (entries[idx].regId == srcReg)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
`ifdef WB_R0_DISCARD_EN
    if (srcReg == '0) begin
      hit  = 1'b0;
      data = '0;
    end
`endif
  end

endmodule

// File: rtl/wb_write_queue.sv
// Circular writeback queue draining oldest-first into the register file, with two forwarding lookups.
// WB_R0_DISCARD_EN: writes to register 0 are accepted but never stored.
module wb_write_queue import wb_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_write_queue_if.slave          bus,
  input  logic [REG_W-1:0]         SrcReg1,
  input  logic [REG_W-1:0]         SrcReg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       slotQ [DEPTH];
  logic [PtrW-1:0] headQ, headD, tailQ, tailD;
  logic [CntW-1:0] countQ, countD;
  logic            accept, doPush, doPop;

  assign bus.in_ready = (countQ != CntW'(DEPTH));
  // Gate with reset so nothing reaches the register file during the reset cycle.
  assign bus.WriteReg = rst & (countQ != '0) & bus.drain_en;
  assign bus.DstReg   = slotQ[headQ].regId;
  assign bus.DstData  = slotQ[headQ].data;
  assign count        = countQ;

  assign accept = bus.in_valid & bus.in_ready;
  assign doPop  = bus.WriteReg;
`ifdef WB_R0_DISCARD_EN
  assign doPush = accept & (bus.in_reg != '0);
`else
  assign doPush = accept;
`endif

  always_comb begin
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ + CntW'(doPush) - CntW'(doPop);
    if (doPush) tailD = tailQ + 1'b1;
    if (doPop)  headD = headQ + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slotQ[i] <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
      if (doPush) slotQ[tailQ] <= '{regId: bus.in_reg, data: bus.in_data};
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (slotQ),
    .head    (headQ),
    .count   (countQ),
    .srcReg  (SrcReg1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (slotQ),
    .head    (headQ),
    .count   (countQ),
    .srcReg  (SrcReg2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback write queue that sits between the execute/memory writeback producers and the register file's single write port. Buffers up to DEPTH completed results, drains them oldest-first into the register file when permitted, and offers two combinational forwarding lookups so decode can read values still pending in the queue. Complements the register file's same-cycle bypass, which only covers the write currently presented on the port.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- REG_W, 4, register-ID width
- DATA_W, 16, data width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  producer offers a result
- in_ready  out  1  queue accepts; push occurs when in_valid & in_ready
- in_reg  in  REG_W  destination register of offered result
- in_data  in  DATA_W  offered result value
- drain_en  in  1  register-file write port available this cycle
- DstReg  out  REG_W  head entry register ID to register file
- DstData  out  DATA_W  head entry data to register file
- WriteReg  out  1  write strobe to register file; pop occurs when high
- SrcReg1, SrcReg2  in  REG_W  decode source IDs to look up
- fwd_hit1, fwd_hit2  out  1  matching entry pending in queue
- fwd_data1, fwd_data2  out  DATA_W  data of youngest matching entry; 0 when no hit
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- Circular buffer: head (read) and tail (write) pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy.
- in_ready = (count != DEPTH); does not depend on drain_en (no combinational ready path).
- WriteReg = (count != 0) & drain_en. DstReg/DstData always show the head slot contents.
- Push: store {in_reg, in_data} at tail, tail+1. Pop: head+1.
- count_next = count + push − pop; simultaneous push and pop keeps count unchanged, including when full is not reached and when count==1 (head and tail advance independently).
- Full: push refused; pop still allowed. Push is not accepted in the same cycle as a pop from full (slot frees next cycle).
- Empty: WriteReg 0 regardless of drain_en; DstReg/DstData show stale slot.
- Forwarding: for each lookup, compare SrcRegN against every valid entry (head up to tail−1); youngest match wins; entry popping this cycle still counts as a hit. Entry being pushed this cycle is not visible until the next cycle.
- Multiple pending writes to the same register drain in order; lookup returns the newest.

## Timing
- Reset (rst==0 at rising edge): head, tail, count = 0; all slots cleared to 0. After reset: in_ready 1, WriteReg 0, DstReg 0, DstData 0, fwd_hit* 0, fwd_data* 0, count 0.
- Reset mid-operation discards all pending entries; no write issued in the reset cycle.
- Push at edge N → entry visible to forwarding and (if queue was empty) on DstReg/WriteReg in cycle N+1; minimum enqueue-to-write latency 1 cycle.
- Forwarding outputs are combinational from SrcRegN and current state, same cycle.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- WB_R0_DISCARD_EN defined: push with in_reg==0 completes handshake but stores nothing (count unchanged by it); lookups with SrcRegN==0 never hit (fwd_hit 0, data 0).
- Undefined: register 0 queued, drained and forwarded like any other register.

## Structure
- Package wb_pkg: REG_W, DATA_W constants; typedef wb_entry_t {reg id, data}.
- Sub-module wb_fwd_match: youngest-first priority search over entry array given head/count; instantiated twice (one per lookup port).

## Test plan
- Reset then push {R3, 0x1234} with drain_en=1 → next cycle WriteReg 1, DstReg 3, DstData 0x1234; following cycle count 0, WriteReg 0.
- drain_en=0, push 4 entries R1..R4 (0x0011..0x0044) → count 4, in_ready 0; 5th offer not accepted; drain_en=1 → four writes in order R1..R4.
- Push {R5,0xAAAA} then {R5,0xBBBB}, drain_en=0, SrcReg1=5 → fwd_hit1 1, fwd_data1 0xBBBB; SrcReg2=6 → fwd_hit2 0, fwd_data2 0.
- Queue at count 2 with drain_en=1 and continuous push → count stays 2 across 8 cycles, pointers wrap, write order matches push order.
- Queue holding 3 entries, assert rst low one cycle → count 0, WriteReg 0, fwd_hit* 0; no writes emitted afterwards.
- With WB_R0_DISCARD_EN: push {R0,0xFFFF} → handshake completes, count stays 0, SrcReg1=0 gives fwd_hit1 0; without macro → count 1, WriteReg with DstReg 0.
